// File: rtl/sdram_qos_arbiter.sv
// Round-robin SDRAM client-port arbiter with urgency override and bounded bursts.
// One owner may issue up to BURST back-to-back transactions before the port rotates.
module sdram_qos_arbiter #(
    parameter int unsigned AN    = 24,
    parameter int unsigned DN    = 16,
    parameter int unsigned IN    = 4,
    parameter int unsigned BURST = 8,
    localparam int unsigned GW   = (IN > 1) ? $clog2(IN) : 1,
    localparam int unsigned CW   = $clog2(BURST + 1)
) (
    input  logic                   clkSYS,
    input  logic                   reset,
    input  logic [IN-1:0][AN-1:0]  in_addr,
    input  logic [IN-1:0][DN-1:0]  in_data,
    input  logic [IN-1:0]          in_wr,
    input  logic [IN-1:0]          in_req,
    input  logic [IN-1:0]          urgent,
    output logic [IN-1:0]          in_ack,
    output logic [AN-1:0]          addr,
    output logic [DN-1:0]          data,
    output logic                   wr,
    output logic                   req,
    input  logic                   ack,
    output logic [GW-1:0]          grant,
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StArb} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] count_q, count_d;
    logic [AN-1:0] addr_q, addr_d;
    logic [DN-1:0] data_q, data_d;
    logic          wr_q, wr_d;

    logic [IN-1:0] urg_req;
    logic [IN-1:0] cand;
    logic [IN-1:0] grant_oh;
    logic [GW-1:0] winner;
    logic [GW-1:0] idx;
    logic [GW-1:0] sel;
    logic          load;
    logic          others_urgent;

    // Rotating search from last+1; walking backwards lets the nearest candidate win.
    always_comb begin
        urg_req = in_req & urgent;
        cand    = (|urg_req) ? urg_req : in_req;
        winner  = last_q;
        idx     = '0;
        for (int i = int'(IN); i > 0; i--) begin
            idx = GW'((int'(last_q) + i) % int'(IN));
            if (cand[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
        others_urgent     = |(urg_req & ~grant_oh);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        load    = 1'b0;
        sel     = grant_q;
        unique case (state_q)
            StIdle: begin
                if (|in_req) begin
                    state_d = StGrant;
                    grant_d = winner;
                    last_d  = winner;
                    count_d = CW'(1);
                    load    = 1'b1;
                    sel     = winner;
                end
            end
            StGrant: begin
                if (ack) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                // Continuation keeps the owner and leaves the rotation pointer alone.
                if (in_req[grant_q] && (count_q < CW'(BURST)) && !others_urgent) begin
                    state_d = StGrant;
                    count_d = count_q + CW'(1);
                    load    = 1'b1;
                    sel     = grant_q;
                end else if (|in_req) begin
                    state_d = StGrant;
                    grant_d = winner;
                    last_d  = winner;
                    count_d = CW'(1);
                    load    = 1'b1;
                    sel     = winner;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        wr_d   = wr_q;
        if (load) begin
            addr_d = in_addr[sel];
            data_d = in_data[sel];
            wr_d   = in_wr[sel];
        end
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= GW'(IN - 1);
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    // Reset suppresses the acknowledge so an aborted transaction is never reported done.
    assign in_ack = (state_q == StGrant && ack && !reset) ? grant_oh : '0;
    assign req    = (state_q == StGrant);
    assign busy   = (state_q != StIdle);
    assign grant  = grant_q;
    assign addr   = addr_q;
    assign data   = data_q;
    assign wr     = wr_q;

endmodule
